// File: rtl/pipelined_multiplier_l2_pkg.sv
// Shared types for the RV32M multiply execute unit.
// Build option: define PIPELINED_MUL_HIGH_EN to add MULH/MULHSU/MULHU
// (a 64-bit product is then carried down the pipe).
package pipelined_multiplier_l2_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned AREG_BITS = 5;

`ifdef PIPELINED_MUL_HIGH_EN
    localparam int unsigned PROD_W = 2 * XLEN;
`else
    localparam int unsigned PROD_W = XLEN;
`endif

    // Micro-ops seen on the issue channel; only the multiply group is executed here.
    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_MUL    = 4'd3,
        OP_MULH   = 4'd4,
        OP_MULHSU = 4'd5,
        OP_MULHU  = 4'd6,
        OP_DIV    = 4'd7
    } rv_uop;

    // Which half of the carried product becomes wdata.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_LO   = 2'd1,
        SEL_HI   = 2'd2
    } res_sel_e;

    // Arithmetic payload carried by every pipe stage.
    typedef struct packed {
        logic            wen;
        res_sel_e        sel;
        logic [PROD_W-1:0] prod;
    } mul_res_t;

    // Final result selection applied after the last stage.
    function automatic logic [XLEN-1:0] sel_result(input mul_res_t r);
        logic [XLEN-1:0] d;
        d = '0;
        case (r.sel)
            SEL_LO:  d = r.prod[XLEN-1:0];
`ifdef PIPELINED_MUL_HIGH_EN
            SEL_HI:  d = r.prod[2*XLEN-1:XLEN];
`endif
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipelined_multiplier_l2_if.sv
// Issue (D__X) and writeback (X__W) channels of the execute stage.
// D__XIntf: val/rdy, pc, seq_num, op1, op2, waddr, uop, preg, ppreg.
// X__WIntf: val/rdy, pc, seq_num, waddr, wdata, wen.
// The execute unit is the slave of D__XIntf and the master of X__WIntf.
interface D__XIntf #(
    parameter int unsigned p_seq_num_bits  = 5,
    parameter int unsigned p_phys_reg_bits = 6
);
    logic                               val;
    logic                               rdy;
    logic [31:0]                        pc;
    logic [p_seq_num_bits-1:0]          seq_num;
    logic [31:0]                        op1;
    logic [31:0]                        op2;
    logic [4:0]                         waddr;
    pipelined_multiplier_l2_pkg::rv_uop uop;
    logic [p_phys_reg_bits-1:0]         preg;
    logic [p_phys_reg_bits-1:0]         ppreg;

    modport master (output val, pc, seq_num, op1, op2, waddr, uop, preg, ppreg,
                    input  rdy);
    modport slave  (input  val, pc, seq_num, op1, op2, waddr, uop, preg, ppreg,
                    output rdy);
endinterface

interface X__WIntf #(
    parameter int unsigned p_seq_num_bits = 5
);
    logic                      val;
    logic                      rdy;
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;

    modport master (output val, pc, seq_num, waddr, wdata, wen,
                    input  rdy);
    modport slave  (input  val, pc, seq_num, waddr, wdata, wen,
                    output rdy);
endinterface

// File: rtl/pipelined_multiplier_l2_mul_pipe_stage.sv
// One val/rdy register slot of the multiply pipe: metadata plus product.
// Ports: clk, rst (sync, active-high); in_* upstream side (in_rdy_c is
// combinational); out_* downstream side (registered).
module mul_pipe_stage
    import pipelined_multiplier_l2_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      in_val,
    output logic                      in_rdy_c,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [p_seq_num_bits-1:0] in_seq_num,
    input  logic [AREG_BITS-1:0]      in_waddr,
    input  mul_res_t                  in_res,

    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [XLEN-1:0]           out_pc,
    output logic [p_seq_num_bits-1:0] out_seq_num,
    output logic [AREG_BITS-1:0]      out_waddr,
    output mul_res_t                  out_res
);

    // Slot can load when empty or when its content leaves on this edge.
    assign in_rdy_c = !out_val || out_rdy;

    // Occupancy bit: the only state that needs reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val <= 1'b0;
        end else if (in_rdy_c) begin
            out_val <= in_val;
        end
    end

    // Payload loads only on an accepted transfer, otherwise holds stable.
    always_ff @(posedge clk) begin
        if (in_val && in_rdy_c) begin
            out_pc      <= in_pc;
            out_seq_num <= in_seq_num;
            out_waddr   <= in_waddr;
            out_res     <= in_res;
        end
    end

endmodule

// File: rtl/pipelined_multiplier_l2.sv
// RV32M multiply execute unit: a p_pipeline_stages-deep val/rdy pipe from the
// issue channel D to the writeback channel W, one op per cycle, in order.
// Ports: clk; rst (sync, active-high); D (D__XIntf.slave); W (X__WIntf.master).
// Build option: PIPELINED_MUL_HIGH_EN enables MULH/MULHSU/MULHU; otherwise
// those uops take the unsupported path (wdata=0, wen=0).
module pipelined_multiplier_l2
    import pipelined_multiplier_l2_pkg::*;
#(
    parameter int unsigned p_pipeline_stages = 1,
    parameter int unsigned p_seq_num_bits    = 5
) (
    input  logic       clk,
    input  logic       rst,
    D__XIntf.slave     D,
    X__WIntf.master    W
);

    localparam int unsigned NSTG = p_pipeline_stages;

    // Index 0 is the issue side, index NSTG is the writeback side.
    logic                      stg_val   [0:NSTG];
    logic                      stg_rdy   [0:NSTG];
    logic [XLEN-1:0]           stg_pc    [0:NSTG];
    logic [p_seq_num_bits-1:0] stg_seq   [0:NSTG];
    logic [AREG_BITS-1:0]      stg_waddr [0:NSTG];
    mul_res_t                  stg_res   [0:NSTG];

    mul_res_t                  in_res_c;

    // preg/ppreg belong to the rename machinery and are not used here.
    logic unused_preg_c;
    assign unused_preg_c = ^{D.preg, D.ppreg};

`ifdef PIPELINED_MUL_HIGH_EN
    // One 66-bit multiply covers all four ops: each operand is sign- or
    // zero-extended as the uop requires, and the low 64 bits are exact.
    logic                  a_msb_c;
    logic                  b_msb_c;
    logic [2*XLEN+1:0]     a_wide_c;
    logic [2*XLEN+1:0]     b_wide_c;
    logic [2*XLEN+1:0]     prod_full_c;
    logic [1:0]            unused_prod_hi_c;

    assign a_msb_c          = D.op1[XLEN-1] && ((D.uop == OP_MULH) || (D.uop == OP_MULHSU));
    assign b_msb_c          = D.op2[XLEN-1] && (D.uop == OP_MULH);
    assign a_wide_c         = {{(XLEN+2){a_msb_c}}, D.op1};
    assign b_wide_c         = {{(XLEN+2){b_msb_c}}, D.op2};
    assign prod_full_c      = a_wide_c * b_wide_c;
    assign unused_prod_hi_c = prod_full_c[2*XLEN+1:2*XLEN];
`else
    logic [XLEN-1:0]       prod_full_c;
    assign prod_full_c = D.op1 * D.op2;
`endif

    // Decode the uop into a result selector and write enable.
    always_comb begin
        in_res_c      = '0;
        in_res_c.prod = prod_full_c[PROD_W-1:0];
        case (D.uop)
            OP_MUL: begin
                in_res_c.wen = 1'b1;
                in_res_c.sel = SEL_LO;
            end
`ifdef PIPELINED_MUL_HIGH_EN
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                in_res_c.wen = 1'b1;
                in_res_c.sel = SEL_HI;
            end
`endif
            default: begin
                in_res_c.wen = 1'b0;
                in_res_c.sel = SEL_ZERO;
            end
        endcase
    end

    assign stg_val[0]   = D.val;
    assign D.rdy        = stg_rdy[0];
    assign stg_pc[0]    = D.pc;
    assign stg_seq[0]   = D.seq_num;
    assign stg_waddr[0] = D.waddr;
    assign stg_res[0]   = in_res_c;

    // Register chain; each slot compacts forward into a free successor.
    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        mul_pipe_stage #(
            .p_seq_num_bits (p_seq_num_bits)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_val      (stg_val[k]),
            .in_rdy_c    (stg_rdy[k]),
            .in_pc       (stg_pc[k]),
            .in_seq_num  (stg_seq[k]),
            .in_waddr    (stg_waddr[k]),
            .in_res      (stg_res[k]),
            .out_val     (stg_val[k+1]),
            .out_rdy     (stg_rdy[k+1]),
            .out_pc      (stg_pc[k+1]),
            .out_seq_num (stg_seq[k+1]),
            .out_waddr   (stg_waddr[k+1]),
            .out_res     (stg_res[k+1])
        );
    end

    // Writeback side: wdata is a fixed selection of the last stage's register.
    assign stg_rdy[NSTG] = W.rdy;
    assign W.val         = stg_val[NSTG];
    assign W.pc          = stg_pc[NSTG];
    assign W.seq_num     = stg_seq[NSTG];
    assign W.waddr       = stg_waddr[NSTG];
    assign W.wdata       = sel_result(stg_res[NSTG]);
    assign W.wen         = stg_res[NSTG].wen;

    // Fixed-width line: accepted op ("pc:uop" or blanks) then one mark per stage.
    function automatic string trace();
        string s;
        string n;
        if (D.val && D.rdy) begin
            n = D.uop.name();
            while (n.len() < 9) n = {n, " "};
            s = $sformatf("%08h:%s", D.pc, n.substr(0, 8));
        end else begin
            s = "                  ";
        end
        for (int k = 1; k <= int'(NSTG); k++) begin
            if (stg_val[k]) s = {s, "|*"};
            else            s = {s, "|."};
        end
        return s;
    endfunction

endmodule

// File: tb/tb_pipelined_multiplier_l2.sv
// Scoreboard bench for pipelined_multiplier_l2: the driver pushes the
// hand-computed expected result when an op is accepted; a monitor pops and
// compares whenever W presents a result.
module tb_pipelined_multiplier_l2;
    import pipelined_multiplier_l2_pkg::*;

    localparam int unsigned P     = 4;
    localparam int unsigned SEQ_W = 5;
    localparam int unsigned SNAP_W = 32 + SEQ_W + 5 + 32 + 1;

    typedef struct {
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
        logic [4:0]       waddr;
        logic [31:0]      wdata;
        logic             wen;
        int               acc;
        bit               chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sink_mode = 0;   // 0 ready, 1 stalled, 2 random
    bit   held = 1'b0;
    logic [SNAP_W-1:0] snap;
    exp_t sb[$];

    D__XIntf #(.p_seq_num_bits(SEQ_W), .p_phys_reg_bits(6)) d_if ();
    X__WIntf #(.p_seq_num_bits(SEQ_W))                      w_if ();

    pipelined_multiplier_l2 #(
        .p_pipeline_stages (P),
        .p_seq_num_bits    (SEQ_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .D   (d_if),
        .W   (w_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready changes just after the rising edge.
    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0:       w_if.rdy = 1'b1;
            1:       w_if.rdy = 1'b0;
            default: w_if.rdy = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Monitor: compare on first presentation, check stability while stalled.
    always @(negedge clk) begin
        if (!rst && w_if.val) begin
            if (held) begin
                checks++;
                if ({w_if.pc, w_if.seq_num, w_if.waddr, w_if.wdata, w_if.wen} !== snap) begin
                    errors++;
                    $display("FAIL stable: W changed while stalled, got %h want %h",
                             {w_if.pc, w_if.seq_num, w_if.waddr, w_if.wdata, w_if.wen}, snap);
                end
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: W.val with no op outstanding, pc=%h seq=%0d",
                         w_if.pc, w_if.seq_num);
            end else begin
                exp_t e;
                e = sb[0];
                checks++;
                if (w_if.pc !== e.pc || w_if.seq_num !== e.seq || w_if.waddr !== e.waddr ||
                    w_if.wdata !== e.wdata || w_if.wen !== e.wen) begin
                    errors++;
                    $display("FAIL result: got pc=%h seq=%0d waddr=%0d wdata=%h wen=%b, want pc=%h seq=%0d waddr=%0d wdata=%h wen=%b",
                             w_if.pc, w_if.seq_num, w_if.waddr, w_if.wdata, w_if.wen,
                             e.pc, e.seq, e.waddr, e.wdata, e.wen);
                end
                if (e.chk_lat) begin
                    checks++;
                    if (cyc - e.acc != int'(P)) begin
                        errors++;
                        $display("FAIL latency: seq=%0d got %0d cycles want %0d",
                                 e.seq, cyc - e.acc, P);
                    end
                end
            end
            if (w_if.rdy) begin
                held = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end else begin
                held = 1'b1;
                snap = {w_if.pc, w_if.seq_num, w_if.waddr, w_if.wdata, w_if.wen};
            end
        end
    end

    task automatic send(input rv_uop uop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [SEQ_W-1:0] seq,
                        input logic [4:0] wa, input logic [31:0] exp_d,
                        input logic exp_wen, input bit chk, output int acc);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        acc   = -1;
        @(negedge clk);
        d_if.val     = 1'b1;
        d_if.uop     = uop;
        d_if.op1     = a;
        d_if.op2     = b;
        d_if.pc      = pc;
        d_if.seq_num = seq;
        d_if.waddr   = wa;
        d_if.preg    = 6'(seq);
        d_if.ppreg   = 6'(wa);
        while (!done) begin
            #4;
            if (d_if.rdy) begin
                exp_t e;
                e.pc = pc; e.seq = seq; e.waddr = wa; e.wdata = exp_d;
                e.wen = exp_wen; e.acc = cyc; e.chk_lat = chk;
                sb.push_back(e);
                acc  = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            if (!done) begin
                guard++;
                if (guard > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL accept: D.rdy stuck low, got 0 want 1 (seq=%0d)", seq);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 d_if.val = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end
    endtask

    // Directed operand tables with hand-computed products.
    logic [31:0] va   [0:7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    logic [31:0] vb   [0:7] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    logic [31:0] vexp [0:7] = '{32'd10, 32'd22, 32'd36, 32'd52, 32'd70, 32'd90, 32'd112, 32'd136};

    initial begin
        int acc;
        int first_acc;
        d_if.val = 1'b0; d_if.uop = OP_NOP; d_if.op1 = '0; d_if.op2 = '0;
        d_if.pc = '0; d_if.seq_num = '0; d_if.waddr = '0; d_if.preg = '0; d_if.ppreg = '0;
        w_if.rdy = 1'b1;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (w_if.val !== 1'b0) begin errors++; $display("FAIL reset_wval: got %b want 0", w_if.val); end
        checks++;
        if (d_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_drdy: got %b want 1", d_if.rdy); end

        // Basic and wrap-around cases
        send(OP_MUL, 32'd3, 32'd4, 32'h200, 5'd1, 5'd5, 32'd12, 1'b1, 1'b1, acc);
        drain();
        send(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'h204, 5'd2, 5'd6, 32'hFFFF_FFFE, 1'b1, 1'b1, acc);
        send(OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h208, 5'd3, 5'd7, 32'h0, 1'b1, 1'b1, acc);
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h20C, 5'd4, 5'd8, 32'h0, 1'b1, 1'b1, acc);
        send(OP_MUL, 32'h1234_5678, 32'h0, 32'h210, 5'd5, 5'd9, 32'h0, 1'b1, 1'b1, acc);
        send(OP_MUL, 32'd5, 32'd7, 32'h214, 5'd6, 5'd0, 32'd35, 1'b1, 1'b1, acc);
        send(OP_ADD, 32'd5, 32'd6, 32'h218, 5'd7, 5'd10, 32'h0, 1'b0, 1'b1, acc);
`ifdef PIPELINED_MUL_HIGH_EN
        send(OP_MULH,   32'hFFFF_FFFF, 32'd2, 32'h21C, 5'd8,  5'd11, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
        send(OP_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h220, 5'd9,  5'd12, 32'h0000_0001, 1'b1, 1'b1, acc);
        send(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'h224, 5'd10, 5'd13, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
        send(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h228, 5'd11, 5'd14, 32'h4000_0000, 1'b1, 1'b1, acc);
`else
        send(OP_MULH,   32'hFFFF_FFFF, 32'd2, 32'h21C, 5'd8,  5'd11, 32'h0, 1'b0, 1'b1, acc);
        send(OP_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h220, 5'd9,  5'd12, 32'h0, 1'b0, 1'b1, acc);
`endif
        drain();

        // Streaming: 8 back-to-back ops must be accepted on consecutive cycles
        first_acc = -1;
        for (int i = 0; i < 8; i++) begin
            send(OP_MUL, va[i], vb[i], 32'h300 + 32'(i * 4), 5'(i), 5'(i + 1), vexp[i], 1'b1, 1'b1, acc);
            if (i == 0) first_acc = acc;
        end
        checks++;
        if (acc - first_acc != 7) begin
            errors++;
            $display("FAIL stream_rate: 8 accepts spanned %0d cycles, want 7", acc - first_acc);
        end
        drain();

        // Random sink backpressure
        sink_mode = 2;
        for (int i = 0; i < 8; i++)
            send(OP_MUL, va[i], vb[i], 32'h400 + 32'(i * 4), 5'(16 + i), 5'(i + 3), vexp[i], 1'b1, 1'b0, acc);
        drain();
        @(posedge clk);
        sink_mode = 0;
        repeat (2) @(posedge clk);

        // Source idles 3 cycles between ops; each result still has exact latency
        for (int i = 0; i < 8; i++) begin
            send(OP_MUL, vb[i], va[i], 32'h500 + 32'(i * 4), 5'(8 + i), 5'(i + 2), vexp[i], 1'b1, 1'b1, acc);
            repeat (3) @(posedge clk);
        end
        drain();

        // Reset with three ops in flight behind a stalled sink
        sink_mode = 1;
        repeat (2) @(posedge clk);
        send(OP_MUL, 32'd2, 32'd2, 32'h600, 5'd1, 5'd1, 32'd4, 1'b1, 1'b0, acc);
        send(OP_MUL, 32'd3, 32'd3, 32'h604, 5'd2, 5'd2, 32'd9, 1'b1, 1'b0, acc);
        send(OP_MUL, 32'd4, 32'd4, 32'h608, 5'd3, 5'd3, 32'd16, 1'b1, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        held = 1'b0;
        sink_mode = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (w_if.val !== 1'b0) begin errors++; $display("FAIL midrst_wval: got %b want 0", w_if.val); end
        checks++;
        if (d_if.rdy !== 1'b1) begin errors++; $display("FAIL midrst_drdy: got %b want 1", d_if.rdy); end
        send(OP_MUL, 32'd7, 32'd6, 32'h700, 5'd4, 5'd9, 32'd42, 1'b1, 1'b1, acc);
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
